lii_phy_arbiter: RTL and testbench
==================================

// Module: lii_phy_arbiter
// PURPOSE
//   Shares one LII physical output channel between NREQ kernel-wrapper output ports.
//   Round-robin arbitration, with the grant held for a burst of up to MAXBURST beats.
//   Each forwarded beat carries the winning requester's src/dst tags unchanged.
//   Sits between several *_wrapper lii_out ports and one phy link, driving it through a registered output stage.
// PARAMETERS
//   NREQ     4   number of requesting streams (2..16)
//   PW       64  packed data width per beat
//   MAXBURST 16  max beats forwarded per grant before re-arbitration (>=1)
// PORTS
//   aclk           in   1        clock
//   arstn          in   1        asynchronous active-low reset
//   req_tdata      in   NREQ*PW  requester data; requester i occupies [i*PW +: PW]
//   req_tvalid     in   NREQ     requester valid
//   req_tready     out  NREQ     requester ready; only the granted bit may be 1
//   req_src        in   NREQ*8   requester source id, [i*8 +: 8]
//   req_dst        in   NREQ*8   requester destination id, [i*8 +: 8]
//   lii_out_tdata  out  PW       phy data (registered)
//   lii_out_tvalid out  1        phy valid (registered)
//   lii_out_tready in   1        phy ready
//   lii_out_src    out  8        phy source tag (registered)
//   lii_out_dst    out  8        phy destination tag (registered)
//   grant_id       out  clog2(NREQ)  index of current or last grant
//   busy           out  1        1 while in GRANT state
// BEHAVIOUR
//   Reset (arstn=0, async): all outputs 0; state=IDLE; rr_ptr=NREQ-1; beat_cnt=0.
//   FSM IDLE:
//     - Search req_tvalid starting at (rr_ptr+1) mod NREQ, wrapping.
//     - On the first hit g: register grant_id=g, beat_cnt=0, go to GRANT next cycle.
//     - With no hit, stay in IDLE; req_tready=0.
//   FSM GRANT:
//     - can_load = !lii_out_tvalid | lii_out_tready.
//     - req_tready[grant_id] = can_load; all other bits 0. Combinational, no dependence on req_tvalid.
//     - xfer = req_tvalid[g] & can_load.
//     - On xfer: load out regs (tdata/src/dst of g); lii_out_tvalid<=1; beat_cnt++.
//     - Release when (xfer & beat_cnt==MAXBURST-1) OR (!req_tvalid[g]), i.e. a gap ends the burst.
//     - On release: rr_ptr<=g; beat_cnt<=0; IDLE next cycle.
//     - A release on the final beat still transfers that beat in the same cycle.
//   Output stage:
//     - If lii_out_tvalid & lii_out_tready and no new load occurs, lii_out_tvalid<=0.
//     - out regs hold stable while lii_out_tvalid & !lii_out_tready.
//   Latency: req beat accepted in cycle t appears on lii_out in cycle t+1.
//   Grant timing: one IDLE arbitration cycle sits between consecutive grants, a 1-bubble minimum.
//     Peak throughput per grant is therefore MAXBURST/(MAXBURST+1).
//   The output stage still drains during IDLE; no beat is dropped or duplicated under backpressure.
//   Requesters must not withdraw tvalid while tready=0 (AXIS rule); withdrawal ends the grant.
//   beat_cnt width: clog2(MAXBURST)+1; never wraps, because release occurs at MAXBURST-1.
//   grant_id holds its last value in IDLE; busy = (state==GRANT).
//   Reset mid-burst: the in-flight output beat is discarded and lii_out_tvalid falls immediately; no recovery.
// TESTING
//   1. Single req0 valid with 20 beats, tready=1, MAXBURST=16:
//      -> 16 beats out, 1 bubble, then 4 beats. src/dst match req0. grant_id=0 throughout.
//   2. req0..3 all valid continuously, MAXBURST=4:
//      -> grants 0,1,2,3,0... Each grant is 4 beats, with exactly 1 idle cycle between grants.
//   3. lii_out_tready=0 for 5 cycles mid-burst:
//      -> lii_out_tdata/src/dst stable; req_tready[g]=0; no beat lost or duplicated (compare via scoreboard).
//   4. req2 drops tvalid after 3 of 16 beats while req1 is waiting:
//      -> grant released; next grant goes to req3 if valid, otherwise wraps to req1.
//   5. Assert arstn=0 during beat 5 of a burst:
//      -> all outputs 0 asynchronously. After release the first grant goes to req0 (rr_ptr=NREQ-1).
//   6. Random valid/ready at 50% for 10k cycles:
//      -> per-requester ordering preserved; req_tready one-hot or zero; no grant longer than MAXBURST beats.

Source files
------------

// File: rtl/lii_phy_arbiter.sv
// lii_phy_arbiter: shares one LII phy output between NREQ streams using round-robin grants.
// A grant lasts up to MAXBURST beats, and the output passes through a registered stage.
module lii_phy_arbiter #(
  parameter int NREQ     = 4,
  parameter int PW       = 64,
  parameter int MAXBURST = 16
) (
  input  logic                     aclk,
  input  logic                     arstn,
  input  logic [NREQ*PW-1:0]       req_tdata,
  input  logic [NREQ-1:0]          req_tvalid,
  output logic [NREQ-1:0]          req_tready,
  input  logic [NREQ*8-1:0]        req_src,
  input  logic [NREQ*8-1:0]        req_dst,
  output logic [PW-1:0]            lii_out_tdata,
  output logic                     lii_out_tvalid,
  input  logic                     lii_out_tready,
  output logic [7:0]               lii_out_src,
  output logic [7:0]               lii_out_dst,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy
);

  localparam int GW = $clog2(NREQ);
  localparam int BW = $clog2(MAXBURST) + 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(MAXBURST - 1);
  localparam logic [GW-1:0] LAST_REQ  = GW'(NREQ - 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_reg, state_next;
  logic [GW-1:0] grant_reg, grant_next;
  logic [GW-1:0] rr_ptr_reg, rr_ptr_next;
  logic [BW-1:0] beat_cnt_reg, beat_cnt_next;
  logic [PW-1:0] out_data_reg, out_data_next;
  logic [7:0]    out_src_reg, out_src_next;
  logic [7:0]    out_dst_reg, out_dst_next;
  logic          out_valid_reg, out_valid_next;

  logic [PW-1:0] data_arr [NREQ];
  logic [7:0]    src_arr  [NREQ];
  logic [7:0]    dst_arr  [NREQ];

  logic          can_load;
  logic          tvalid_g;
  logic          xfer;
  logic          hit;
  logic [GW-1:0] hit_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_req
      assign data_arr[gi]   = req_tdata[gi*PW +: PW];
      assign src_arr[gi]    = req_src[gi*8 +: 8];
      assign dst_arr[gi]    = req_dst[gi*8 +: 8];
      assign req_tready[gi] = (state_reg == GRANT) && (grant_reg == GW'(gi)) && can_load;
    end
  endgenerate

  assign can_load = !out_valid_reg || lii_out_tready;
  assign tvalid_g = req_tvalid[grant_reg];
  assign xfer     = (state_reg == GRANT) && tvalid_g && can_load;

  // First valid requester after the last winner, wrapping around.
  always_comb begin
    int idx;
    idx     = 0;
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr_reg) + 1 + k) % NREQ;
      if (!hit && req_tvalid[GW'(idx)]) begin
        hit     = 1'b1;
        hit_idx = GW'(idx);
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    rr_ptr_next    = rr_ptr_reg;
    beat_cnt_next  = beat_cnt_reg;
    out_data_next  = out_data_reg;
    out_src_next   = out_src_reg;
    out_dst_next   = out_dst_reg;
    out_valid_next = out_valid_reg;

    // The output stage drains in any state; a new load overrides the drain.
    if (out_valid_reg && lii_out_tready) begin
      out_valid_next = 1'b0;
    end
    if (xfer) begin
      out_data_next  = data_arr[grant_reg];
      out_src_next   = src_arr[grant_reg];
      out_dst_next   = dst_arr[grant_reg];
      out_valid_next = 1'b1;
      beat_cnt_next  = beat_cnt_reg + BW'(1);
    end

    case (state_reg)
      IDLE: begin
        if (hit) begin
          grant_next    = hit_idx;
          beat_cnt_next = '0;
          state_next    = GRANT;
        end
      end
      GRANT: begin
        // Burst ends on its last beat or as soon as the winner drops valid.
        if ((xfer && (beat_cnt_reg == LAST_BEAT)) || !tvalid_g) begin
          rr_ptr_next   = grant_reg;
          beat_cnt_next = '0;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state_reg     <= IDLE;
      grant_reg     <= '0;
      rr_ptr_reg    <= LAST_REQ;
      beat_cnt_reg  <= '0;
      out_data_reg  <= '0;
      out_src_reg   <= '0;
      out_dst_reg   <= '0;
      out_valid_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      rr_ptr_reg    <= rr_ptr_next;
      beat_cnt_reg  <= beat_cnt_next;
      out_data_reg  <= out_data_next;
      out_src_reg   <= out_src_next;
      out_dst_reg   <= out_dst_next;
      out_valid_reg <= out_valid_next;
    end
  end

  assign lii_out_tdata  = out_data_reg;
  assign lii_out_tvalid = out_valid_reg;
  assign lii_out_src    = out_src_reg;
  assign lii_out_dst    = out_dst_reg;
  assign grant_id       = grant_reg;
  assign busy           = (state_reg == GRANT);

endmodule

// File: tb/tb_lii_phy_arbiter.sv
// tb_lii_phy_arbiter: directed and random checks of the round-robin phy arbiter
// (NREQ=4, PW=16, MAXBURST=4); beat data is {requester[3:0], sequence[11:0]}.
module tb_lii_phy_arbiter;
  localparam int NREQ = 4;
  localparam int PW   = 16;
  localparam int MB   = 4;

  logic                 aclk = 1'b0;
  logic                 arstn = 1'b0;
  logic [NREQ*PW-1:0]   req_tdata;
  logic [NREQ-1:0]      req_tvalid;
  logic [NREQ-1:0]      req_tready;
  logic [NREQ*8-1:0]    req_src;
  logic [NREQ*8-1:0]    req_dst;
  logic [PW-1:0]        lii_out_tdata;
  logic                 lii_out_tvalid;
  logic                 lii_out_tready;
  logic [7:0]           lii_out_src;
  logic [7:0]           lii_out_dst;
  logic [1:0]           grant_id;
  logic                 busy;

  lii_phy_arbiter #(.NREQ(NREQ), .PW(PW), .MAXBURST(MB)) dut (
    .aclk(aclk), .arstn(arstn),
    .req_tdata(req_tdata), .req_tvalid(req_tvalid), .req_tready(req_tready),
    .req_src(req_src), .req_dst(req_dst),
    .lii_out_tdata(lii_out_tdata), .lii_out_tvalid(lii_out_tvalid),
    .lii_out_tready(lii_out_tready), .lii_out_src(lii_out_src),
    .lii_out_dst(lii_out_dst), .grant_id(grant_id), .busy(busy)
  );

  always #5 aclk = ~aclk;

  int n_vec = 0;
  int n_bad = 0;
  int seq[NREQ];
  int remaining[NREQ];
  int out_seq[NREQ];
  bit vld[NREQ];
  bit rand_mode = 1'b0;
  bit rand_on = 1'b0;
  logic [31:0] sb[$];
  int log_req[$];
  bit vtrace[$];
  int run_len = 0;

  logic            s_valid, s_busy;
  logic [PW-1:0]   s_tdata;
  logic [7:0]      s_src, s_dst;
  logic [NREQ-1:0] s_tready;
  logic [1:0]      s_grant;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req_tdata[i*PW +: PW] = {4'(i), 12'(seq[i])};
      req_tvalid[i]         = vld[i];
      req_src[i*8 +: 8]     = 8'(8'h10 + i);
      req_dst[i*8 +: 8]     = 8'(8'hA0 + i);
    end
  endtask

  task automatic load(int i, int n);
    remaining[i] = n;
    vld[i] = (n > 0);
    drive_inputs();
  endtask

  function automatic bit any_vld();
    bit a = 1'b0;
    for (int i = 0; i < NREQ; i++) a = a | vld[i];
    return a;
  endfunction

  // One clock: sample at the falling edge, score, then update requesters after the rising edge.
  task automatic tick();
    logic [NREQ-1:0] in_hs;
    logic            out_hs;
    logic [31:0]     e;
    int              r;
    @(negedge aclk);
    s_valid  = lii_out_tvalid;
    s_busy   = busy;
    s_tdata  = lii_out_tdata;
    s_src    = lii_out_src;
    s_dst    = lii_out_dst;
    s_tready = req_tready;
    s_grant  = grant_id;
    vtrace.push_back(s_valid);
    in_hs  = req_tvalid & req_tready;
    out_hs = lii_out_tvalid & lii_out_tready;
    chk("tready_onehot0", 64'($onehot0(s_tready)), 64'd1);
    if (s_busy) run_len += (in_hs != '0) ? 1 : 0;
    else run_len = 0;
    chk("burst_len", 64'(run_len <= MB), 64'd1);
    if (out_hs) begin
      r = int'(s_tdata[15:12]);
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'(sb.size()), 64'd1);
      end else begin
        e = sb.pop_front();
        chk("beat", {32'd0, s_tdata, s_src, s_dst}, {32'd0, e});
      end
      if (r < NREQ) begin
        chk($sformatf("order_req%0d", r), 64'(s_tdata[11:0]), 64'(out_seq[r]));
        out_seq[r]++;
      end
      log_req.push_back(r);
      $display("beat req=%0d seq=%0d src=%02h dst=%02h t=%0t", r, s_tdata[11:0], s_src, s_dst, $time);
    end
    for (int i = 0; i < NREQ; i++)
      if (in_hs[i]) sb.push_back({4'(i), 12'(seq[i]), 8'(8'h10 + i), 8'(8'hA0 + i)});
    @(posedge aclk);
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (in_hs[i]) begin
        seq[i]++;
        if (remaining[i] > 0) remaining[i]--;
      end
      if (rand_mode) begin
        if (!(vld[i] && !in_hs[i])) vld[i] = rand_on ? 1'($urandom_range(0, 1)) : 1'b0;
      end else begin
        vld[i] = (remaining[i] > 0);
      end
    end
    if (rand_mode) lii_out_tready = rand_on ? 1'($urandom_range(0, 1)) : 1'b1;
    drive_inputs();
  endtask

  task automatic clear_model();
    for (int i = 0; i < NREQ; i++) begin
      seq[i] = 0; remaining[i] = 0; out_seq[i] = 0; vld[i] = 1'b0;
    end
    sb.delete();
    log_req.delete();
    rand_mode = 1'b0;
    rand_on = 1'b0;
    lii_out_tready = 1'b1;
    run_len = 0;
    drive_inputs();
  endtask

  task automatic do_reset();
    arstn = 1'b0;
    clear_model();
    tick();
    tick();
    arstn = 1'b1;
    tick();
  endtask

  task automatic drain(string tag, int max_ticks);
    int n = 0;
    while (n < max_ticks && (any_vld() || sb.size() != 0 || lii_out_tvalid)) begin
      tick();
      n++;
    end
    chk({tag, "_drained"}, 64'(n < max_ticks), 64'd1);
    chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  task automatic check_order(string tag, int exp[$]);
    chk({tag, "_count"}, 64'(log_req.size()), 64'(exp.size()));
    for (int k = 0; k < exp.size() && k < log_req.size(); k++)
      chk($sformatf("%s_beat%0d_req", tag, k), 64'(log_req[k]), 64'(exp[k]));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_v, last_v, zeros;
    int ord[$];
    logic [9:0] vbits, bbits;

    lii_out_tready = 1'b1;
    clear_model();
    do_reset();

    // Reset state
    chk("rst_valid", 64'(s_valid), 64'd0);
    chk("rst_tdata", 64'(s_tdata), 64'd0);
    chk("rst_src", 64'(s_src), 64'd0);
    chk("rst_dst", 64'(s_dst), 64'd0);
    chk("rst_busy", 64'(s_busy), 64'd0);
    chk("rst_grant", 64'(s_grant), 64'd0);
    chk("rst_tready", 64'(s_tready), 64'd0);

    // Single requester, 6 beats with burst limit 4: 4 beats, one bubble, 2 beats
    load(0, 6);
    vbits = '0;
    bbits = '0;
    for (int c = 0; c < 10; c++) begin
      tick();
      vbits = {vbits[8:0], s_valid};
      bbits = {bbits[8:0], s_busy};
      if (s_busy) chk("t1_grant", 64'(s_grant), 64'd0);
    end
    chk("t1_valid_trace", 64'(vbits), 64'(10'b0011110110));
    chk("t1_busy_trace", 64'(bbits), 64'(10'b0111101110));
    drain("t1", 40);
    ord = '{0, 0, 0, 0, 0, 0};
    check_order("t1", ord);

    // All four requesters, 8 beats each: grants 0,1,2,3,0,1,2,3 with one bubble between
    do_reset();
    vtrace.delete();
    for (int i = 0; i < NREQ; i++) load(i, 8);
    drain("t2", 200);
    ord.delete();
    for (int k = 0; k < 32; k++) ord.push_back((k / 4) % 4);
    check_order("t2", ord);
    first_v = -1; last_v = -1; zeros = 0;
    foreach (vtrace[k]) if (vtrace[k]) begin
      if (first_v < 0) first_v = k;
      last_v = k;
    end
    for (int k = 0; k < vtrace.size(); k++)
      if (first_v >= 0 && k > first_v && k < last_v && !vtrace[k]) zeros++;
    chk("t2_bubbles", 64'(zeros), 64'd7);

    // Backpressure for 5 cycles with beat 1 on the output
    do_reset();
    load(0, 8);
    repeat (3) tick();
    lii_out_tready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t3_hold_valid", 64'(s_valid), 64'd1);
      chk("t3_hold_tdata", 64'(s_tdata), 64'h0001);
      chk("t3_hold_src", 64'(s_src), 64'h10);
      chk("t3_hold_dst", 64'(s_dst), 64'hA0);
      chk("t3_req_tready", 64'(s_tready), 64'd0);
    end
    lii_out_tready = 1'b1;
    drain("t3", 60);
    ord = '{0, 0, 0, 0, 0, 0, 0, 0};
    check_order("t3", ord);

    // req2 stops after 3 beats while req1 and req3 wait: next grant is req3, then req1
    do_reset();
    load(1, 1);
    drain("t4a_pre", 40);
    log_req.delete();
    load(2, 3); load(1, 2); load(3, 2);
    drain("t4a", 80);
    ord = '{2, 2, 2, 3, 3, 1, 1};
    check_order("t4a", ord);

    // Same without req3: the grant wraps to req1
    do_reset();
    load(1, 1);
    drain("t4b_pre", 40);
    log_req.delete();
    load(2, 3); load(1, 2);
    drain("t4b", 80);
    ord = '{2, 2, 2, 1, 1};
    check_order("t4b", ord);

    // Reset mid-burst: outputs clear without a clock edge; first grant afterwards is req0
    do_reset();
    load(0, 1);
    drain("t5_pre", 40);
    load(2, 10);
    repeat (4) tick();
    chk("t5_pre_valid", 64'(s_valid), 64'd1);
    chk("t5_pre_grant", 64'(s_grant), 64'd2);
    #1 arstn = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(lii_out_tvalid), 64'd0);
    chk("t5_rst_tdata", 64'(lii_out_tdata), 64'd0);
    chk("t5_rst_src", 64'(lii_out_src), 64'd0);
    chk("t5_rst_dst", 64'(lii_out_dst), 64'd0);
    chk("t5_rst_tready", 64'(req_tready), 64'd0);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_grant", 64'(grant_id), 64'd0);
    clear_model();
    tick();
    tick();
    arstn = 1'b1;
    tick();
    load(0, 2); load(1, 2);
    drain("t5", 40);
    ord = '{0, 0, 1, 1};
    check_order("t5", ord);

    // Random valid/ready: ordering, one-hot ready and burst length checked every cycle
    do_reset();
    rand_mode = 1'b1;
    rand_on = 1'b1;
    repeat (600) tick();
    rand_on = 1'b0;
    drain("t6", 300);
    chk("t6_activity", 64'(log_req.size() > 50), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
